// File: rtl/uart_lite_pkg.sv
// Shared definitions for the UART Lite AXI scheduler:
// register map, STAT bit positions, FSM states and grant encoding.
package uart_lite_pkg;

  localparam int REG_RX   = 'h0;
  localparam int REG_TX   = 'h4;
  localparam int REG_STAT = 'h8;
  localparam int REG_CTRL = 'hC;

  localparam int STAT_RXVALID = 0;
  localparam int STAT_TXFULL  = 3;
  localparam int STAT_OVR     = 5;
  localparam int STAT_FRM     = 6;
  localparam int STAT_PAR     = 7;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [3:0] {
    S_INIT_AW,
    S_INIT_B,
    S_IDLE,
    S_STAT_AR,
    S_STAT_R,
    S_DATA_AR,
    S_DATA_R,
    S_DATA_AW,
    S_DATA_B
  } sched_state_e;

  typedef enum logic {
    GRANT_RX = 1'b0,
    GRANT_TX = 1'b1
  } grant_e;

endpackage

// File: rtl/uart_lite_axi_scheduler_axil.sv
// AXI-Lite master engine: one read or one write per command pulse,
// AW and W valids dropping independently, single outstanding transaction.
module axil_single_master #(
  parameter int ADDR_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cmd_rd_i,
  input  logic              cmd_wr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic              addr_ack_o,
  output logic              done_o,
  output logic              busy_o,
  output logic [31:0]       rdata_o,
  output logic [1:0]        resp_o,
  output logic [ADDR_W-1:0] awaddr_o,
  output logic              awvalid_o,
  input  logic              awready_i,
  output logic [31:0]       wdata_o,
  output logic              wvalid_o,
  input  logic              wready_i,
  input  logic [1:0]        bresp_i,
  input  logic              bvalid_i,
  output logic              bready_o,
  output logic [ADDR_W-1:0] araddr_o,
  output logic              arvalid_o,
  input  logic              arready_i,
  input  logic [31:0]       rdata_i,
  input  logic [1:0]        rresp_i,
  input  logic              rvalid_i,
  output logic              rready_o
);

  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              awdone_q, awdone_d;
  logic              wdone_q, wdone_d;
  logic              bready_q, bready_d;

  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_ack;

  assign ar_hs  = arvalid_q & arready_i;
  assign r_hs   = rready_q & rvalid_i;
  assign aw_hs  = awvalid_q & awready_i;
  assign w_hs   = wvalid_q & wready_i;
  assign b_hs   = bready_q & bvalid_i;
  assign wr_ack = (awvalid_q | wvalid_q)
                & (awdone_q | aw_hs)
                & (wdone_q | w_hs);

  // Next-state for every channel flag; handshakes retire their valid.
  always_comb begin
    arvalid_d = arvalid_q;
    rready_d  = rready_q;
    araddr_d  = araddr_q;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    awdone_d  = awdone_q;
    wdone_d   = wdone_q;
    bready_d  = bready_q;
    if (cmd_rd_i) begin
      arvalid_d = 1'b1;
      araddr_d  = addr_i;
    end
    if (ar_hs) begin
      arvalid_d = 1'b0;
      rready_d  = 1'b1;
    end
    if (r_hs) rready_d = 1'b0;
    if (cmd_wr_i) begin
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
      awaddr_d  = addr_i;
      wdata_d   = wdata_i;
      awdone_d  = 1'b0;
      wdone_d   = 1'b0;
    end
    if (aw_hs) begin
      awvalid_d = 1'b0;
      awdone_d  = 1'b1;
    end
    if (w_hs) begin
      wvalid_d = 1'b0;
      wdone_d  = 1'b1;
    end
    if (wr_ack) begin
      bready_d = 1'b1;
      awdone_d = 1'b0;
      wdone_d  = 1'b0;
    end
    if (b_hs) bready_d = 1'b0;
  end

  // Channel state registers; reset drops every valid/ready at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      araddr_q  <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awdone_q  <= 1'b0;
      wdone_q   <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      araddr_q  <= araddr_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awdone_q  <= awdone_d;
      wdone_q   <= wdone_d;
      bready_q  <= bready_d;
    end
  end

  assign addr_ack_o = ar_hs | wr_ack;
  assign done_o     = r_hs | b_hs;
  assign busy_o     = arvalid_q | rready_q | awvalid_q
                    | wvalid_q | bready_q;
  assign rdata_o    = rdata_i;
  assign resp_o     = rready_q ? rresp_i : bresp_i;
  assign awaddr_o   = awaddr_q;
  assign awvalid_o  = awvalid_q;
  assign wdata_o    = wdata_q;
  assign wvalid_o   = wvalid_q;
  assign bready_o   = bready_q;
  assign araddr_o   = araddr_q;
  assign arvalid_o  = arvalid_q;
  assign rready_o   = rready_q;

endmodule

// File: rtl/uart_lite_axi_scheduler.sv
// Shares one UART Lite slave between the RX consumer and the TX sender:
// FIFO init, STAT polling before each data access, round-robin grants.
module uart_lite_axi_scheduler
  import uart_lite_pkg::*;
#(
  parameter int         ADDR_W    = 4,
  parameter logic [7:0] INIT_CTRL = 8'h03
) (
  input  logic              m_axi_aclk,
  input  logic              rst,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [31:0]       m_axi_wdata,
  output logic [3:0]        m_axi_wstrb,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic [1:0]        m_axi_bresp,
  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  output logic [ADDR_W-1:0] m_axi_araddr,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [31:0]       m_axi_rdata,
  input  logic [1:0]        m_axi_rresp,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  input  logic              read_signal,
  output logic              read_valid,
  output logic [7:0]        read_data,
  input  logic              infer_ready,
  input  logic [4:0]        winner_ID,
  output logic              busy,
  output logic [3:0]        err_flags
);

  sched_state_e state_q, state_d;
  grant_e       grant_q, grant_d;
  grant_e       last_q, last_d;
  logic         rx_pend_q, rx_pend_d;
  logic         tx_pend_q, tx_pend_d;
  logic [7:0]   tx_byte_q, tx_byte_d;
  logic [7:0]   rdata_q, rdata_d;
  logic         rvalid_q, rvalid_d;
  logic         busy_q, busy_d;
  logic [3:0]   err_q, err_d;

  logic              cmd_rd, cmd_wr;
  logic [ADDR_W-1:0] cmd_addr;
  logic [31:0]       cmd_wdata;
  logic              m_ack, m_done, m_busy;
  logic [31:0]       m_rdata;
  logic [1:0]        m_resp;
  logic              unused_rdata;

  assign unused_rdata = ^m_rdata[31:8];

  axil_single_master #(.ADDR_W(ADDR_W)) u_mst (
    .clk_i      (m_axi_aclk),
    .rst_i      (rst),
    .cmd_rd_i   (cmd_rd),
    .cmd_wr_i   (cmd_wr),
    .addr_i     (cmd_addr),
    .wdata_i    (cmd_wdata),
    .addr_ack_o (m_ack),
    .done_o     (m_done),
    .busy_o     (m_busy),
    .rdata_o    (m_rdata),
    .resp_o     (m_resp),
    .awaddr_o   (m_axi_awaddr),
    .awvalid_o  (m_axi_awvalid),
    .awready_i  (m_axi_awready),
    .wdata_o    (m_axi_wdata),
    .wvalid_o   (m_axi_wvalid),
    .wready_i   (m_axi_wready),
    .bresp_i    (m_axi_bresp),
    .bvalid_i   (m_axi_bvalid),
    .bready_o   (m_axi_bready),
    .araddr_o   (m_axi_araddr),
    .arvalid_o  (m_axi_arvalid),
    .arready_i  (m_axi_arready),
    .rdata_i    (m_axi_rdata),
    .rresp_i    (m_axi_rresp),
    .rvalid_i   (m_axi_rvalid),
    .rready_o   (m_axi_rready)
  );

  // Request latching, arbitration, STAT decode and command issue.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    rx_pend_d = rx_pend_q;
    tx_pend_d = tx_pend_q;
    tx_byte_d = tx_byte_q;
    rdata_d   = rdata_q;
    rvalid_d  = 1'b0;
    err_d     = err_q;
    cmd_rd    = 1'b0;
    cmd_wr    = 1'b0;
    cmd_addr  = ADDR_W'(REG_STAT);
    cmd_wdata = '0;

    if (read_signal) rx_pend_d = 1'b1;
    if (infer_ready) begin
      if (tx_pend_q) begin
        err_d[3] = 1'b1;
      end else begin
        tx_pend_d = 1'b1;
        tx_byte_d = {3'b000, winner_ID};
      end
    end

    unique case (state_q)
      S_INIT_AW: begin
        cmd_addr  = ADDR_W'(REG_CTRL);
        cmd_wdata = {24'h0, INIT_CTRL};
        cmd_wr    = ~m_busy;
        if (m_ack) state_d = S_INIT_B;
      end
      S_INIT_B, S_DATA_B: begin
        if (m_done) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (rx_pend_q | tx_pend_q) begin
          if (rx_pend_q & tx_pend_q)
            grant_d = (last_q == GRANT_TX) ? GRANT_RX : GRANT_TX;
          else
            grant_d = rx_pend_q ? GRANT_RX : GRANT_TX;
          last_d  = grant_d;
          cmd_rd  = 1'b1;
          state_d = S_STAT_AR;
        end
      end
      S_STAT_AR: begin
        if (m_ack) state_d = S_STAT_R;
      end
      S_STAT_R: begin
        if (m_done) begin
          err_d[2:0] = err_d[2:0] | {m_rdata[STAT_PAR],
                                     m_rdata[STAT_FRM],
                                     m_rdata[STAT_OVR]};
          if (grant_q == GRANT_RX && m_rdata[STAT_RXVALID]) begin
            cmd_rd   = 1'b1;
            cmd_addr = ADDR_W'(REG_RX);
            state_d  = S_DATA_AR;
          end else if (grant_q == GRANT_TX && !m_rdata[STAT_TXFULL]) begin
            cmd_wr    = 1'b1;
            cmd_addr  = ADDR_W'(REG_TX);
            cmd_wdata = {24'h0, tx_byte_q};
            state_d   = S_DATA_AW;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA_AR: begin
        if (m_ack) state_d = S_DATA_R;
      end
      S_DATA_R: begin
        if (m_done) begin
          if (m_resp == RESP_OKAY) begin
            rdata_d   = m_rdata[7:0];
            rvalid_d  = 1'b1;
            rx_pend_d = 1'b0;
          end
          state_d = S_IDLE;
        end
      end
      S_DATA_AW: begin
        if (m_ack) begin
          tx_pend_d = 1'b0;
          state_d   = S_DATA_B;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d = (state_d != S_IDLE) | rx_pend_d | tx_pend_d;

  // Scheduler state; reset loses pending requests, clears sticky errors.
  always_ff @(posedge m_axi_aclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_INIT_AW;
      grant_q   <= GRANT_RX;
      last_q    <= GRANT_TX;
      rx_pend_q <= 1'b0;
      tx_pend_q <= 1'b0;
      tx_byte_q <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      rx_pend_q <= rx_pend_d;
      tx_pend_q <= tx_pend_d;
      tx_byte_q <= tx_byte_d;
      rdata_q   <= rdata_d;
      rvalid_q  <= rvalid_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign m_axi_wstrb = 4'b0001;
  assign read_valid  = rvalid_q;
  assign read_data   = rdata_q;
  assign busy        = busy_q;
  assign err_flags   = err_q;

endmodule

// File: doc/uart_lite_axi_scheduler.md
Name:
uart_lite_axi_scheduler

Overview:
- Single AXI-Lite master that shares the UART Lite slave between two requesters: the RX byte consumer (`read_signal`) and the inference-result sender (`infer_ready`/`winner_ID`).
- Initialises the UART FIFOs, polls STAT before every data access, and round-robins the two requesters.
- Sits between the SNN core and `axi_uartlite_0`, replacing ad-hoc per-requester AXI sequencing.

Parameters:
- ADDR_W, 4: AXI address width (UART Lite map: 0x0 RX, 0x4 TX, 0x8 STAT, 0xC CTRL).
- INIT_CTRL, 8'h03: byte written to CTRL after reset (bit0 resets the TX FIFO, bit1 resets the RX FIFO).

Ports:
- m_axi_aclk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- m_axi_awaddr  out  ADDR_W  write address.
- m_axi_awvalid / m_axi_awready  out / in  1  write-address handshake.
- m_axi_wdata  out  32  write data.
- m_axi_wstrb  out  4  write strobe; constant 4'b0001.
- m_axi_wvalid / m_axi_wready  out / in  1  write-data handshake.
- m_axi_bresp  in  2  write response.
- m_axi_bvalid / m_axi_bready  in / out  1  write-response handshake.
- m_axi_araddr  out  ADDR_W  read address.
- m_axi_arvalid / m_axi_arready  out / in  1  read-address handshake.
- m_axi_rdata  in  32  read data.
- m_axi_rresp  in  2  read response.
- m_axi_rvalid / m_axi_rready  in / out  1  read-data handshake.
- read_signal  in  1  one-cycle pulse: request one RX byte.
- read_valid  out  1  one-cycle pulse: read_data holds the byte.
- read_data  out  8  received byte.
- infer_ready  in  1  one-cycle pulse: winner_ID is valid.
- winner_ID  in  5  class index to transmit.
- busy  out  1  state != IDLE, or any request pending.
- err_flags  out  4  sticky flags: {tx_drop, parity, frame, overrun}.

Behaviour:
- Reset state: every output 0, state INIT_AW, rx_pend=0, tx_pend=0, last_grant=TX (so RX wins the first tie).
- Request capture:
  - read_signal sets rx_pend.
  - infer_ready sets tx_pend and loads tx_byte={3'b0,winner_ID}.
  - infer_ready while tx_pend=1: tx_byte is not overwritten; err_flags[3] is set.
  - Both pulses in the same cycle: both latch.
- States: INIT_AW, INIT_B, IDLE, STAT_AR, STAT_R, DATA_AR, DATA_R, DATA_AW, DATA_B.
- INIT_AW:
  - Drives awaddr=0xC, wdata=INIT_CTRL, awvalid=wvalid=1.
  - Each valid drops independently once its ready is sampled.
  - Moves to INIT_B when both channels have handshaken.
- INIT_B / DATA_B: bready=1; on bvalid go to IDLE. bresp is ignored.
- IDLE:
  - No pending request: stay.
  - One pending: grant it.
  - Both pending: grant the requester != last_grant.
  - Store grant, update last_grant, go to STAT_AR.
- STAT_AR: araddr=0x8, arvalid=1 until arready. STAT_R: rready=1; on rvalid capture stat=rdata[7:0].
  - On every STAT read: OR stat[7:5] into err_flags[2:0].
  - Grant RX and stat[0]=1: go to DATA_AR with araddr=0x0.
  - Grant TX and stat[3]=0: go to DATA_AW.
  - Otherwise: go to IDLE with the request still pending; round-robin lets the other requester in.
- DATA_R:
  - rready=1; on rvalid register read_data=rdata[7:0].
  - Next cycle read_valid=1 for exactly one cycle; clear rx_pend.
- DATA_AW:
  - Same independent-valid handshake as INIT_AW, with awaddr=0x4 and wdata={24'b0,tx_byte}.
  - Clear tx_pend once both channels have handshaken, then go to DATA_B.
- Transaction rules:
  - At most one outstanding AXI transaction.
  - arvalid and awvalid are never high together.
  - Address and data are stable while valid is high.
- Latency, slave answering with zero wait states:
  - read_signal to read_valid is 7 cycles: capture, IDLE, STAT_AR, STAT_R, DATA_AR, DATA_R, pulse.
  - infer_ready to wvalid high is 5 cycles.
- rresp != OKAY on a data read: discard the byte and keep rx_pend set so the read is retried.
- read_signal arriving while a read is in flight: a second rx_pend is not queued. The pulse is absorbed if it lands before rx_pend clears.
- rst asserted mid-transaction: every valid and ready output drops asynchronously and all pending requests are lost. The UART slave shares this reset (axi_rstn is derived from rst).
- err_flags clear only on rst.

Decomposition:
- Shared package `uart_lite_pkg`:
  - Register offsets RX=0x0, TX=0x4, STAT=0x8, CTRL=0xC.
  - STAT bit indices: RXVALID=0, TXFULL=3, OVR=5, FRM=6, PAR=7.
  - State enum, RESP_OKAY.
- One sub-module `axil_single_master`: one read or one write per command, independent-valid AW/W handling, done/rdata/resp outputs. The scheduler holds only arbitration, polling and request latches.

Test Plan:
- Reset release with a zero-wait slave: first transaction is a write to 0xC with wdata=0x03 and wstrb=4'b0001; no other AXI activity until read_signal or infer_ready.
- STAT=0x01, RX FIFO=0x5A, read_signal pulse: araddr sequence 0x8 then 0x0; read_valid pulses once, 7 cycles later, with read_data=0x5A.
- STAT=0x04, infer_ready with winner_ID=17: one write to 0x4 with wdata=0x00000011; tx_pend clears; busy returns to 0.
- STAT=0x00 for 3 polls then 0x01, read_signal: exactly 4 STAT reads, then one RX read; read_valid pulses once.
- read_signal and infer_ready in the same cycle, STAT=0x05:
  - RX is served first, then TX.
  - Repeat: grants alternate RX/TX.
  - A second infer_ready while tx_pend=1 sets err_flags[3]; the first winner value is still the one transmitted.
- STAT=0xE1 returned once: err_flags=4'b0111 and held. Assert rst while arvalid=1: arvalid drops the same cycle; after release the INIT write repeats; err_flags=0.
